search_requester: RTL and testbench

Synthesizable request side of the search-RAM protocol: buffers search keys from an upstream source, issues them one at a time to the search engine as `search_i`/`key_i`, then waits for the `hit_vd_i` strobe or a timeout. Each completed search is reported as a single-cycle result record, and saturating hit/miss/timeout statistics are kept. The block sits between the packet classifier front end and the search engine, on the same bus the search monitor observes.

---
 rtl/search_requester.sv | 208 ++++++++++++++++++++
 tb/tb_search_requester.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/search_requester.sv
// Request side of the search-RAM protocol: queues keys, issues one search at a
// time, waits for hit_vd_i or a timeout, and reports each outcome with statistics.
module search_requester #(
  parameter int unsigned C_NUM_TABLE      = 4,
  parameter int unsigned C_RULE_WIDTH     = 24,
  parameter int unsigned C_MEM_DATA_WIDTH = 56,
  parameter int unsigned C_MEM_ADDR_WIDTH = 8,
  parameter int unsigned C_FIFO_DEPTH     = 8,
  parameter int unsigned C_TIMEOUT        = 64
) (
  input  logic                                     clk_i,
  input  logic                                     rstn,
  input  logic                                     req_valid_i,
  input  logic [C_RULE_WIDTH-1:0]                  req_key_i,
  output logic                                     req_ready_o,
  output logic                                     search_o,
  output logic [C_RULE_WIDTH-1:0]                  key_o,
  input  logic [C_NUM_TABLE-1:0]                   ready_i,
  input  logic [C_NUM_TABLE-1:0]                   busy_i,
  input  logic                                     hit_vd_i,
  input  logic                                     hit_i,
  input  logic [3:0]                               hit_tab_i,
  input  logic [C_MEM_ADDR_WIDTH-1:0]              hit_addr_i,
  input  logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] hit_data_i,
  output logic                                     res_valid_o,
  output logic                                     res_hit_o,
  output logic                                     res_timeout_o,
  output logic [C_RULE_WIDTH-1:0]                  res_key_o,
  output logic [3:0]                               res_tab_o,
  output logic [C_MEM_ADDR_WIDTH-1:0]              res_addr_o,
  output logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] res_data_o,
  input  logic                                     clr_cnt_i,
  output logic [15:0]                              hit_cnt_o,
  output logic [15:0]                              miss_cnt_o,
  output logic [15:0]                              tmo_cnt_o,
  output logic                                     stray_o,
  output logic                                     idle_o
);

  localparam int unsigned DW = C_MEM_DATA_WIDTH - C_RULE_WIDTH;
  localparam int unsigned AW = C_MEM_ADDR_WIDTH;
  localparam int unsigned KW = C_RULE_WIDTH;
  localparam int unsigned PW = $clog2(C_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(C_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   mem [C_FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [KW-1:0]   key_q, key_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            res_hit_q, res_hit_d, res_tmo_q, res_tmo_d;
  logic [KW-1:0]   res_key_q, res_key_d;
  logic [3:0]      res_tab_q, res_tab_d;
  logic [AW-1:0]   res_addr_q, res_addr_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic [15:0]     hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, tmo_cnt_q, tmo_cnt_d;
  logic            stray_q, stray_d;
  logic            push, pop, engine_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req_ready_o = (count_q != CW'(C_FIFO_DEPTH)) & rstn;
  assign push        = req_valid_i & req_ready_o;
  assign engine_ok   = (&ready_i) & ~(|busy_i);
  assign pop         = (state_q == S_IDLE) & (count_q != '0) & engine_ok;

  // Key FIFO storage; the data array needs no reset since count gates reads.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= req_key_i;
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Search sequencing, result capture and statistics
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    timer_d    = timer_q;
    res_hit_d  = res_hit_q;
    res_tmo_d  = res_tmo_q;
    res_key_d  = res_key_q;
    res_tab_d  = res_tab_q;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    stray_d    = stray_q | (hit_vd_i & (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          key_d   = mem[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (hit_vd_i) begin
          res_hit_d  = hit_i;
          res_tmo_d  = 1'b0;
          res_key_d  = key_q;
          res_tab_d  = hit_i ? hit_tab_i  : '0;
          res_addr_d = hit_i ? hit_addr_i : '0;
          res_data_d = hit_i ? hit_data_i : '0;
          state_d    = S_REPORT;
        end else if (timer_q == TW'(C_TIMEOUT - 1)) begin
          res_hit_d  = 1'b0;
          res_tmo_d  = 1'b1;
          res_key_d  = key_q;
          res_tab_d  = '0;
          res_addr_d = '0;
          res_data_d = '0;
          state_d    = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_tmo_q)      tmo_cnt_d  = sat_inc(tmo_cnt_q);
        else if (res_hit_q) hit_cnt_d  = sat_inc(hit_cnt_q);
        else                miss_cnt_d = sat_inc(miss_cnt_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A clear overrides any increment or stray detection in the same cycle.
    if (clr_cnt_i) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      tmo_cnt_d  = '0;
      stray_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      key_q      <= '0;
      timer_q    <= '0;
      res_hit_q  <= 1'b0;
      res_tmo_q  <= 1'b0;
      res_key_q  <= '0;
      res_tab_q  <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      key_q      <= key_d;
      timer_q    <= timer_d;
      res_hit_q  <= res_hit_d;
      res_tmo_q  <= res_tmo_d;
      res_key_q  <= res_key_d;
      res_tab_q  <= res_tab_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      stray_q    <= stray_d;
    end
  end

  assign search_o      = (state_q == S_ISSUE);
  assign res_valid_o   = (state_q == S_REPORT);
  assign key_o         = key_q;
  assign res_hit_o     = res_hit_q;
  assign res_timeout_o = res_tmo_q;
  assign res_key_o     = res_key_q;
  assign res_tab_o     = res_tab_q;
  assign res_addr_o    = res_addr_q;
  assign res_data_o    = res_data_q;
  assign hit_cnt_o     = hit_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;
  assign tmo_cnt_o     = tmo_cnt_q;
  assign stray_o       = stray_q;
  assign idle_o        = (state_q == S_IDLE) & (count_q == '0);

endmodule

// File: tb/tb_search_requester.sv
// Bench for search_requester: directed stimulus with a queue-based scoreboard
// checking every search_o key and every result record.
module tb_search_requester;

  localparam int unsigned NT = 4;
  localparam int unsigned KW = 24;
  localparam int unsigned MW = 56;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = MW - KW;

  logic          clk_i, rstn;
  logic          req_valid_i, req_ready_o;
  logic [KW-1:0] req_key_i, key_o, res_key_o;
  logic          search_o;
  logic [NT-1:0] ready_i, busy_i;
  logic          hit_vd_i, hit_i;
  logic [3:0]    hit_tab_i, res_tab_o;
  logic [AW-1:0] hit_addr_i, res_addr_o;
  logic [DW-1:0] hit_data_i, res_data_o;
  logic          res_valid_o, res_hit_o, res_timeout_o;
  logic          clr_cnt_i, stray_o, idle_o;
  logic [15:0]   hit_cnt_o, miss_cnt_o, tmo_cnt_o;

  search_requester #(
    .C_NUM_TABLE(NT), .C_RULE_WIDTH(KW), .C_MEM_DATA_WIDTH(MW),
    .C_MEM_ADDR_WIDTH(AW), .C_FIFO_DEPTH(8), .C_TIMEOUT(64)
  ) dut (
    .clk_i(clk_i), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_key_i(req_key_i), .req_ready_o(req_ready_o),
    .search_o(search_o), .key_o(key_o), .ready_i(ready_i), .busy_i(busy_i),
    .hit_vd_i(hit_vd_i), .hit_i(hit_i), .hit_tab_i(hit_tab_i),
    .hit_addr_i(hit_addr_i), .hit_data_i(hit_data_i),
    .res_valid_o(res_valid_o), .res_hit_o(res_hit_o), .res_timeout_o(res_timeout_o),
    .res_key_o(res_key_o), .res_tab_o(res_tab_o), .res_addr_o(res_addr_o),
    .res_data_o(res_data_o), .clr_cnt_i(clr_cnt_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .tmo_cnt_o(tmo_cnt_o),
    .stray_o(stray_o), .idle_o(idle_o)
  );

  typedef struct {
    logic          hit;
    logic          tmo;
    logic [KW-1:0] key;
    logic [3:0]    tab;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } res_t;

  res_t          exp_res[$];
  logic [KW-1:0] exp_key[$];
  int            n_pass = 0;
  int            n_total = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [KW-1:0] k);
    exp_key.push_back(k);
    req_key_i   = k;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_search(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk_i);
      if (search_o) found = 1'b1;
    end
  endtask

  // Engine model: answer the next search 'delay' cycles after its search_o cycle.
  task automatic respond(input int bound, input int delay, input logic [KW-1:0] key,
                         input logic hit, input logic [3:0] tab,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit   f;
    res_t e;
    wait_search(bound, f);
    chk("search_seen", 64'(f), 64'd1);
    if (f) begin
      repeat (delay) tick();
      e.hit = hit; e.tmo = 1'b0; e.key = key;
      e.tab  = hit ? tab  : 4'd0;
      e.addr = hit ? addr : '0;
      e.data = hit ? data : '0;
      exp_res.push_back(e);
      hit_vd_i = 1'b1; hit_i = hit; hit_tab_i = tab; hit_addr_i = addr; hit_data_i = data;
      tick();
      hit_vd_i = 1'b0; hit_i = 1'b0; hit_tab_i = '0; hit_addr_i = '0; hit_data_i = '0;
    end
  endtask

  task automatic chk_cnts(input string tag, input int h, input int m, input int t);
    chk({tag, "_hit_cnt"},  64'(hit_cnt_o),  64'(h));
    chk({tag, "_miss_cnt"}, 64'(miss_cnt_o), 64'(m));
    chk({tag, "_tmo_cnt"},  64'(tmo_cnt_o),  64'(t));
  endtask

  // Scoreboard monitor
  initial begin
    logic [KW-1:0] k;
    res_t          e;
    forever begin
      @(negedge clk_i);
      if (search_o) begin
        chk("search_expected", 64'(exp_key.size() != 0), 64'd1);
        if (exp_key.size() != 0) begin
          k = exp_key.pop_front();
          chk("search_key", 64'(key_o), 64'(k));
        end
      end
      if (res_valid_o) begin
        chk("result_expected", 64'(exp_res.size() != 0), 64'd1);
        if (exp_res.size() != 0) begin
          e = exp_res.pop_front();
          chk("res_hit",     64'(res_hit_o),     64'(e.hit));
          chk("res_timeout", 64'(res_timeout_o), 64'(e.tmo));
          chk("res_key",     64'(res_key_o),     64'(e.key));
          chk("res_tab",     64'(res_tab_o),     64'(e.tab));
          chk("res_addr",    64'(res_addr_o),    64'(e.addr));
          chk("res_data",    64'(res_data_o),    64'(e.data));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   f, acc;
    int   n, seen;
    res_t e;

    rstn = 1'b0; req_valid_i = 1'b0; req_key_i = '0; ready_i = '0; busy_i = '0;
    hit_vd_i = 1'b0; hit_i = 1'b0; hit_tab_i = '0; hit_addr_i = '0; hit_data_i = '0;
    clr_cnt_i = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk_i);
    chk("rst_search",    64'(search_o),    64'd0);
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("rst_key",       64'(key_o),       64'd0);
    chk("rst_res_fields", 64'({res_hit_o, res_timeout_o, res_tab_o, res_addr_o, res_data_o}), 64'd0);
    chk("rst_res_key",   64'(res_key_o),   64'd0);
    chk_cnts("rst", 0, 0, 0);
    chk("rst_stray",     64'(stray_o),     64'd0);
    chk("rst_idle",      64'(idle_o),      64'd1);
    chk("rst_ready_low", 64'(req_ready_o), 64'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk_i);
    chk("ready_after_rst", 64'(req_ready_o), 64'd1);
    tick();

    // Basic hit
    ready_i = 4'hF;
    push(24'h00ABCD);
    respond(20, 2, 24'h00ABCD, 1'b1, 4'd2, 8'h3C, 32'hDEADBEEF);
    repeat (2) tick();
    @(negedge clk_i);
    chk_cnts("hit1", 1, 0, 0);
    chk("hold_res_addr", 64'(res_addr_o), 64'h3C);
    chk("idle_after_hit", 64'(idle_o), 64'd1);
    tick();

    // Engine busy holds off the issue; miss zeroes the hit fields
    busy_i = 4'b0100;
    push(24'h123456);
    seen = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (search_o) seen++;
    end
    chk("no_search_while_busy", 64'(seen), 64'd0);
    tick();
    busy_i = 4'b0000;
    respond(2, 1, 24'h123456, 1'b0, 4'd5, 8'h77, 32'h1234);
    repeat (2) tick();
    @(negedge clk_i);
    chk_cnts("miss", 1, 1, 0);
    tick();

    // Timeout: result exactly 64 cycles after WAIT_HIT entry
    push(24'hC0FFEE);
    wait_search(20, f);
    chk("tmo_search_seen", 64'(f), 64'd1);
    e.hit = 1'b0; e.tmo = 1'b1; e.key = 24'hC0FFEE; e.tab = '0; e.addr = '0; e.data = '0;
    exp_res.push_back(e);
    n = 0; acc = 1'b0;
    for (int i = 1; i <= 100 && !acc; i++) begin
      @(negedge clk_i);
      if (res_valid_o) begin acc = 1'b1; n = i; end
    end
    chk("timeout_latency", 64'(n), 64'd65);
    repeat (2) tick();
    @(negedge clk_i);
    chk_cnts("tmo", 1, 1, 1);
    tick();

    // hit_vd_i on the last WAIT_HIT cycle beats the timeout
    push(24'h0F0F0F);
    respond(20, 64, 24'h0F0F0F, 1'b1, 4'd7, 8'hA5, 32'hCAFEF00D);
    repeat (2) tick();
    @(negedge clk_i);
    chk_cnts("late_hit", 2, 1, 1);
    tick();

    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
    @(negedge clk_i);
    chk_cnts("clr", 0, 0, 0);
    tick();

    // Fill the FIFO with the engine stalled, then drain in order
    ready_i = 4'h0;
    for (int i = 0; i < 9; i++) exp_key.push_back(24'h100000 + 24'(i));
    for (int i = 0; i < 9; i++) begin
      req_key_i   = 24'h100000 + 24'(i);
      req_valid_i = 1'b1;
      @(negedge clk_i);
      chk("ready_fill", 64'(req_ready_o), 64'(i < 8));
      tick();
    end
    ready_i = 4'hF;
    fork
      begin
        acc = 1'b0;
        for (int j = 0; j < 200 && !acc; j++) begin
          @(negedge clk_i);
          if (req_ready_o) begin
            acc = 1'b1;
            tick();
            req_valid_i = 1'b0;
          end
        end
        chk("ninth_accepted", 64'(acc), 64'd1);
        req_valid_i = 1'b0;
      end
      begin
        for (int i = 0; i < 9; i++)
          respond(40, 1, 24'h100000 + 24'(i), 1'(i % 2 == 0), 4'(i),
                  8'(i * 16 + 1), 32'(i) * 32'h01010101);
      end
    join
    repeat (2) tick();
    @(negedge clk_i);
    chk_cnts("drain", 5, 4, 0);
    chk("idle_after_drain", 64'(idle_o), 64'd1);
    tick();

    // Stray strobe in IDLE
    hit_vd_i = 1'b1;
    tick();
    hit_vd_i = 1'b0;
    repeat (2) tick();
    @(negedge clk_i);
    chk("stray_set", 64'(stray_o), 64'd1);
    tick();

    // Clear coinciding with the REPORT increment
    push(24'h5A5A5A);
    respond(20, 1, 24'h5A5A5A, 1'b1, 4'd3, 8'h11, 32'h22);
    clr_cnt_i = 1'b1;
    @(negedge clk_i);
    chk("clr_in_report", 64'(res_valid_o), 64'd1);
    tick();
    clr_cnt_i = 1'b0;
    @(negedge clk_i);
    chk_cnts("clr_report", 0, 0, 0);
    chk("stray_cleared", 64'(stray_o), 64'd0);
    tick();

    // Reset mid-search drops the key; the late strobe is a stray
    push(24'h777777);
    wait_search(20, f);
    chk("rst_mid_search_seen", 64'(f), 64'd1);
    tick();
    rstn = 1'b0;
    @(negedge clk_i);
    chk("ready_low_in_rst", 64'(req_ready_o), 64'd0);
    tick();
    rstn = 1'b1;
    hit_vd_i = 1'b1; hit_i = 1'b1;
    tick();
    hit_vd_i = 1'b0; hit_i = 1'b0;
    repeat (2) tick();
    @(negedge clk_i);
    chk("late_strobe_stray", 64'(stray_o),   64'd1);
    chk("idle_after_rst",    64'(idle_o),    64'd1);
    chk("res_hit_rst",       64'(res_hit_o), 64'd0);

    repeat (5) tick();
    chk("keys_drained",    64'(exp_key.size()), 64'd0);
    chk("results_drained", 64'(exp_res.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
